// File: rtl/hop_pulse_seq.sv
// Pulse sequencer and latency checker for the three-flop hop chain.
// Fires single-cycle start pulses, scores each ff3 return against LAT, and keeps pass/fail counts.
module hop_pulse_seq #(
  parameter int unsigned GAP_W   = 8,
  parameter int unsigned LAT     = 3,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clock0,
  input  logic             rst2,
  input  logic             enable,
  input  logic [GAP_W-1:0] gap,
  input  logic [7:0]       count,
  input  logic             ff3_in,
  output logic             start,
  output logic             busy,
  output logic             done,
  output logic [7:0]       pass_cnt,
  output logic [7:0]       fail_cnt,
  output logic             err
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LAT_C   = CNT_W'(LAT);
  localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRE,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic               en_q;
  logic [GAP_W-1:0]   gap_q, gap_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [CNT_W-1:0]   rem_q, rem_n;
  logic               finite_q, finite_n;
  logic [CNT_W-1:0]   lat_cnt, lat_n;
  logic [CNT_W-1:0]   pass_n, fail_n;
  logic               err_n;
  logic               start_n, busy_n, done_n;
  logic               verdict_c, pass_c;

  // State, run context and registered outputs
  always_ff @(posedge clock0 or negedge rst2) begin
    if (!rst2) begin
      state    <= S_IDLE;
      en_q     <= 1'b0;
      gap_q    <= '0;
      gap_cnt  <= '0;
      rem_q    <= '0;
      finite_q <= 1'b0;
      lat_cnt  <= '0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      start    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      en_q     <= enable;
      gap_q    <= gap_n;
      gap_cnt  <= gap_cnt_n;
      rem_q    <= rem_n;
      finite_q <= finite_n;
      lat_cnt  <= lat_n;
      pass_cnt <= pass_n;
      fail_cnt <= fail_n;
      err      <= err_n;
      start    <= start_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  // Next-state, scoring and output decode
  always_comb begin
    state_n   = state;
    gap_n     = gap_q;
    gap_cnt_n = gap_cnt;
    rem_n     = rem_q;
    finite_n  = finite_q;
    lat_n     = lat_cnt;
    pass_n    = pass_cnt;
    fail_n    = fail_cnt;
    err_n     = err;
    verdict_c = 1'b0;
    pass_c    = 1'b0;

    case (state)
      S_IDLE: begin
        // en_q delays run start by one cycle after enable is first seen
        if (en_q && enable) begin
          state_n  = S_FIRE;
          gap_n    = gap;
          rem_n    = count;
          finite_n = (count != '0);
          pass_n   = '0;
          fail_n   = '0;
          err_n    = 1'b0;
        end
      end
      S_FIRE: begin
        // lat_cnt holds cycles elapsed since FIRE, so the first WAIT cycle reads 1
        lat_n   = CNT_W'(1);
        state_n = enable ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (ff3_in) begin
          verdict_c = 1'b1;
          pass_c    = (lat_cnt == LAT_C);
        end else if (lat_cnt == TO_C) begin
          verdict_c = 1'b1;
        end else begin
          lat_n = lat_cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (gap_cnt == '0) begin
          state_n = S_FIRE;
        end else begin
          gap_cnt_n = gap_cnt - GAP_W'(1);
        end
      end
      S_DONE: begin
        if (!enable) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase

    if (verdict_c) begin
      if (pass_c) begin
        if (pass_cnt != CNT_MAX) pass_n = pass_cnt + CNT_W'(1);
      end else begin
        if (fail_cnt != CNT_MAX) fail_n = fail_cnt + CNT_W'(1);
        err_n = 1'b1;
      end
      if (finite_q) begin
        rem_n = rem_q - CNT_W'(1);
      end
      if (finite_q && (rem_q == CNT_W'(1))) begin
        state_n = S_DONE;
      end else if (gap_q == '0) begin
        state_n = S_FIRE;
      end else begin
        state_n   = S_GAP;
        gap_cnt_n = gap_q - GAP_W'(1);
      end
    end

    start_n = (state_n == S_FIRE);
    busy_n  = (state_n == S_FIRE) || (state_n == S_WAIT) || (state_n == S_GAP);
    done_n  = (state_n == S_DONE);
  end

endmodule

// File: tb/tb_hop_pulse_seq.sv
// Bench for hop_pulse_seq: loops start back through a 3-flop chain model or ties ff3_in,
// runs a table of finite runs, then hand-written abort, saturation and reset sequences.
module tb_hop_pulse_seq;

  logic       clock0;
  logic       rst2;
  logic       enable;
  logic [7:0] gap;
  logic [7:0] count;
  logic       ff3_in;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] pass_cnt;
  logic [7:0] fail_cnt;
  logic       err;

  // 0 = loopback through chain, 1 = ff3_in tied 0, 2 = ff3_in tied 1
  int mode;
  logic c1, c2, c3;

  int errors = 0;
  int checks = 0;

  hop_pulse_seq dut (
    .clock0   (clock0),
    .rst2     (rst2),
    .enable   (enable),
    .gap      (gap),
    .count    (count),
    .ff3_in   (ff3_in),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .pass_cnt (pass_cnt),
    .fail_cnt (fail_cnt),
    .err      (err)
  );

  initial begin
    clock0 = 1'b0;
    forever #5 clock0 = ~clock0;
  end

  always_ff @(posedge clock0 or negedge rst2) begin
    if (!rst2) begin
      c1 <= 1'b0;
      c2 <= 1'b0;
      c3 <= 1'b0;
    end else begin
      c1 <= start;
      c2 <= c1;
      c3 <= c2;
    end
  end

  assign ff3_in = (mode == 0) ? c3 : (mode == 2);

  typedef struct {
    int gap;
    int count;
    int mode;
    int n_starts;
    int period;
    int s2d;
    int pass;
    int fail;
    int err;
  } row_t;

  row_t rows [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_row(input int r);
    int first;
    int last;
    int nst;
    int done_at;
    logic [7:0] p_hold;
    gap   = 8'(rows[r].gap);
    count = 8'(rows[r].count);
    mode  = rows[r].mode;
    @(negedge clock0);
    enable  = 1'b1;
    first   = -1;
    last    = -1;
    nst     = 0;
    done_at = -1;
    for (int i = 1; i <= 200 && done_at < 0; i++) begin
      @(negedge clock0);
      if (start) begin
        if (first < 0) first = i;
        else chk($sformatf("r%0d_period", r), 32'(i - last), 32'(rows[r].period));
        last = i;
        nst++;
      end
      if (done && done_at < 0) done_at = i;
    end
    chk($sformatf("r%0d_first_start", r), 32'(first), 32'd2);
    chk($sformatf("r%0d_n_starts", r), 32'(nst), 32'(rows[r].n_starts));
    chk($sformatf("r%0d_done_at", r), 32'(done_at), 32'(2 + rows[r].s2d));
    chk($sformatf("r%0d_pass", r), 32'(pass_cnt), 32'(rows[r].pass));
    chk($sformatf("r%0d_fail", r), 32'(fail_cnt), 32'(rows[r].fail));
    chk($sformatf("r%0d_err", r), 32'(err), 32'(rows[r].err));
    chk($sformatf("r%0d_busy_in_done", r), 32'(busy), 32'd0);
    p_hold = pass_cnt;
    repeat (3) @(negedge clock0);
    chk($sformatf("r%0d_done_hold", r), 32'({done, start, pass_cnt}), 32'({1'b1, 1'b0, p_hold}));
    enable = 1'b0;
    @(negedge clock0);
    chk($sformatf("r%0d_idle_after", r), 32'({done, busy, pass_cnt}), 32'({2'b00, p_hold}));
  endtask

  initial begin
    int nst;
    int seen;
    logic any;

    rows[0] = '{0, 1, 0, 1, 0,  4, 1, 0, 0};
    rows[1] = '{2, 4, 0, 4, 6, 22, 4, 0, 0};
    rows[2] = '{0, 2, 1, 2, 16, 32, 0, 2, 1};
    rows[3] = '{0, 3, 2, 3, 2,  6, 0, 3, 1};
    rows[4] = '{0, 3, 0, 3, 4, 12, 3, 0, 0};
    rows[5] = '{3, 1, 1, 1, 0, 16, 0, 1, 1};
    rows[6] = '{5, 2, 0, 2, 9, 13, 2, 0, 0};

    // Reset holds every output low while inputs wiggle
    rst2   = 1'b0;
    enable = 1'b0;
    gap    = 8'd0;
    count  = 8'd0;
    mode   = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock0);
      enable = ~enable;
      gap    = 8'($urandom_range(0, 255));
      count  = 8'($urandom_range(0, 255));
      mode   = i % 3;
      #1;
      chk("reset_outputs", 32'({start, busy, done, err, pass_cnt, fail_cnt}), 32'd0);
    end
    @(negedge clock0);
    enable = 1'b0;
    mode   = 0;
    rst2   = 1'b1;
    any    = 1'b0;
    repeat (5) begin
      @(negedge clock0);
      any = any | start | busy | done;
    end
    chk("idle_after_reset", 32'(any), 32'd0);

    for (int r = 0; r < 7; r++) run_row(r);

    // Continuous run, abort in GAP after 5 pulses
    mode  = 0;
    gap   = 8'd2;
    count = 8'd0;
    @(negedge clock0);
    enable = 1'b1;
    nst = 0;
    for (int i = 0; i < 100 && nst < 5; i++) begin
      @(negedge clock0);
      if (start) nst++;
    end
    chk("cont_five_starts", 32'(nst), 32'd5);
    repeat (4) @(negedge clock0);
    chk("cont_in_gap", 32'({busy, start, pass_cnt}), 32'({2'b10, 8'd5}));
    enable = 1'b0;
    @(negedge clock0);
    chk("cont_abort_idle", 32'({busy, done, pass_cnt, fail_cnt}), 32'({2'b00, 8'd5, 8'd0}));
    any = 1'b0;
    repeat (20) begin
      @(negedge clock0);
      any = any | start;
    end
    chk("cont_no_more_start", 32'(any), 32'd0);
    chk("cont_pass_held", 32'(pass_cnt), 32'd5);

    // Abort during WAIT: the in-flight pulse is not scored
    gap = 8'd0;
    @(negedge clock0);
    enable = 1'b1;
    nst = 0;
    for (int i = 0; i < 100 && nst < 2; i++) begin
      @(negedge clock0);
      if (start) nst++;
    end
    chk("wait_abort_two_starts", 32'(nst), 32'd2);
    @(negedge clock0);
    chk("wait_abort_busy", 32'(busy), 32'd1);
    enable = 1'b0;
    @(negedge clock0);
    chk("wait_abort_idle", 32'(busy), 32'd0);
    repeat (10) @(negedge clock0);
    chk("wait_abort_counts", 32'({pass_cnt, fail_cnt, 7'd0, err}), 32'({8'd1, 8'd0, 8'd0}));

    // Early fails at period 2 drive fail_cnt into saturation
    mode = 2;
    @(negedge clock0);
    enable = 1'b1;
    repeat (600) @(negedge clock0);
    chk("sat_fail_cnt", 32'(fail_cnt), 32'd255);
    chk("sat_err_pass", 32'({err, pass_cnt}), 32'({1'b1, 8'd0}));
    enable = 1'b0;
    @(negedge clock0);

    // Asynchronous reset mid-run drops start before the next clock edge
    mode = 0;
    @(negedge clock0);
    enable = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clock0);
      if (start) seen = 1;
    end
    chk("arst_saw_start", 32'(seen), 32'd1);
    rst2 = 1'b0;
    #1;
    chk("arst_outputs", 32'({start, busy, done, err, pass_cnt, fail_cnt}), 32'd0);
    enable = 1'b0;
    @(negedge clock0);
    rst2 = 1'b1;
    @(negedge clock0);
    chk("arst_idle", 32'({start, busy}), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
